// File: rtl/aurora_clk_pkg.sv
// Shared types and helpers for the Aurora clocking sequencer.
// Holds the state encoding and the shared counter width helper.
package aurora_clk_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_GT   = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    localparam int unsigned RETRY_W = 8;
    localparam int unsigned LOSS_W  = 16;

    // Counter width: enough bits for the longest interval, plus one
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/aurora_lock_sync.sv
// Two-flop synchronizer for an asynchronous lock indication.
// Resets to "not locked".
module aurora_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two-stage capture into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/aurora_mmcm_seq.sv
// Reset/lock sequencer for the Aurora MMCM and transmit-clock buffer.
// Define AURORA_MMCM_SEQ_STATS_EN to build the lock-loss counter.
module aurora_mmcm_seq
    import aurora_clk_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = 128,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned STABLE_CYCLES       = 256,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic        INIT_CLK,
    input  logic        INIT_RESETN,
    input  logic        GT_PLL_LOCKED,
    input  logic        MMCM_LOCKED,
    input  logic        RESTART,
    output logic        MMCM_RST,
    output logic        TX_CLK_CLR,
    output logic        AURORA_RESET,
    output logic        READY,
    output logic        FAULT,
    output logic [7:0]  RETRY_COUNT,
    output logic [15:0] LOCK_LOSS_COUNT
);

    localparam int unsigned CW = cnt_width(
        RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);

    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that saw lock is the first stable sample
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 2);

    logic          gt_lk;
    logic          mm_lk;
    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic [7:0]    retry_sat;
    logic          retry_over;
    logic          run_drop;
    logic          run_keep;

    aurora_lock_sync u_gt_sync (
        .clk      (INIT_CLK),
        .rst_n    (INIT_RESETN),
        .async_in (GT_PLL_LOCKED),
        .sync_out (gt_lk)
    );

    aurora_lock_sync u_mm_sync (
        .clk      (INIT_CLK),
        .rst_n    (INIT_RESETN),
        .async_in (MMCM_LOCKED),
        .sync_out (mm_lk)
    );

    assign retry_sat  = (RETRY_COUNT == 8'hFF) ? 8'hFF
                                               : RETRY_COUNT + 8'd1;
    assign retry_over = 32'(retry_sat) > MAX_RETRIES;
    assign run_drop   = RESTART || !gt_lk || !mm_lk;
    assign run_keep   = (state == ST_RUN) && !run_drop;

    // Sequencer state, shared interval counter and retry tally
    always_ff @(posedge INIT_CLK) begin
        if (!INIT_RESETN) begin
            state       <= ST_WAIT_GT;
            cnt         <= '0;
            RETRY_COUNT <= '0;
        end else if (RESTART) begin
            state       <= ST_WAIT_GT;
            cnt         <= '0;
            RETRY_COUNT <= '0;
        end else begin
            unique case (state)
                ST_WAIT_GT: begin
                    cnt <= '0;
                    if (gt_lk) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!gt_lk) begin
                        state <= ST_WAIT_GT;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!gt_lk) begin
                        state <= ST_WAIT_GT;
                        cnt   <= '0;
                    end else if (mm_lk) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        RETRY_COUNT <= retry_sat;
                        state       <= retry_over ? ST_FAULT : ST_HOLD;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!gt_lk) begin
                        state <= ST_WAIT_GT;
                        cnt   <= '0;
                    end else if (!mm_lk) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STB_LAST) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        RETRY_COUNT <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= '0;
                    if (!gt_lk)      state <= ST_WAIT_GT;
                    else if (!mm_lk) state <= ST_HOLD;
                end
                ST_FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    state <= ST_WAIT_GT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Registered outputs; READY drops on the same edge RUN is left
    always_ff @(posedge INIT_CLK) begin
        if (!INIT_RESETN) begin
            MMCM_RST     <= 1'b1;
            TX_CLK_CLR   <= 1'b1;
            AURORA_RESET <= 1'b1;
            READY        <= 1'b0;
            FAULT        <= 1'b0;
        end else begin
            MMCM_RST     <= state inside {ST_WAIT_GT, ST_HOLD, ST_FAULT};
            TX_CLK_CLR   <= state inside {ST_WAIT_GT, ST_HOLD, ST_FAULT};
            READY        <= run_keep;
            AURORA_RESET <= !run_keep;
            FAULT        <= (state == ST_FAULT) && !RESTART;
        end
    end

`ifdef AURORA_MMCM_SEQ_STATS_EN
    // Count lock losses seen while running, saturating
    always_ff @(posedge INIT_CLK) begin
        if (!INIT_RESETN) begin
            LOCK_LOSS_COUNT <= '0;
        end else if (state == ST_RUN && !RESTART &&
                     (!gt_lk || !mm_lk) &&
                     LOCK_LOSS_COUNT != 16'hFFFF) begin
            LOCK_LOSS_COUNT <= LOCK_LOSS_COUNT + 16'd1;
        end
    end
`else
    assign LOCK_LOSS_COUNT = '0;
`endif

endmodule

// File: tb/tb_aurora_mmcm_seq.sv
// Directed bench for aurora_mmcm_seq.
// Works with and without AURORA_MMCM_SEQ_STATS_EN.
module tb_aurora_mmcm_seq;
    import aurora_clk_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gt_in;
    logic        mm_in;
    logic        restart;
    logic        mmcm_rst;
    logic        tx_clr;
    logic        aur_rst;
    logic        ready;
    logic        fault;
    logic [7:0]  retry;
    logic [15:0] loss;

    int checks = 0;
    int errors = 0;
    int n;
    logic [15:0] loss1_exp;
    logic [15:0] loss2_exp;

    // Timeout raised to 64 so the 50-cycle lock delay is not a retry
    aurora_mmcm_seq #(
        .RST_HOLD_CYCLES     (8),
        .LOCK_TIMEOUT_CYCLES (64),
        .STABLE_CYCLES       (16),
        .MAX_RETRIES         (2)
    ) dut (
        .INIT_CLK        (clk),
        .INIT_RESETN     (rst_n),
        .GT_PLL_LOCKED   (gt_in),
        .MMCM_LOCKED     (mm_in),
        .RESTART         (restart),
        .MMCM_RST        (mmcm_rst),
        .TX_CLK_CLR      (tx_clr),
        .AURORA_RESET    (aur_rst),
        .READY           (ready),
        .FAULT           (fault),
        .RETRY_COUNT     (retry),
        .LOCK_LOSS_COUNT (loss)
    );

    always #5 clk = ~clk;

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return mmcm_rst;
            1:       return ready;
            default: return fault;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val,
                            output int cyc);
        cyc = 0;
        while (pick(sel) !== val && cyc < 2000) begin
            tick(1);
            cyc++;
        end
    endtask

    initial begin
`ifdef AURORA_MMCM_SEQ_STATS_EN
        loss1_exp = 16'd1;
        loss2_exp = 16'd2;
`else
        loss1_exp = 16'd0;
        loss2_exp = 16'd0;
`endif
        rst_n   = 1'b0;
        gt_in   = 1'b0;
        mm_in   = 1'b0;
        restart = 1'b0;
        tick(3);
        chk("rst_mmcm_rst", mmcm_rst, 1);
        chk("rst_tx_clr", tx_clr, 1);
        chk("rst_aur_rst", aur_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retry", retry, 0);
        chk("rst_loss", loss, 0);
        rst_n = 1'b1;

        // Bring-up: GT lock at cycle 10, HOLD lasts 8 cycles
        tick(10);
        gt_in = 1'b1;
        tick(11);
        chk("hold_last", mmcm_rst, 1);
        tick(1);
        chk("hold_fall", mmcm_rst, 0);
        chk("hold_fall_clr", tx_clr, 0);
        chk("hold_fall_aur", aur_rst, 1);

        // MMCM lock 50 cycles later, READY 19 cycles after that
        tick(50);
        mm_in = 1'b1;
        tick(18);
        chk("rdy_early", ready, 0);
        chk("rdy_early_aur", aur_rst, 1);
        tick(1);
        chk("rdy_on", ready, 1);
        chk("rdy_on_aur", aur_rst, 0);
        chk("rdy_retry", retry, 0);

        // GT lock loss in RUN
        gt_in = 1'b0;
        tick(2);
        chk("gtloss_still", ready, 1);
        tick(1);
        chk("gtloss_ready", ready, 0);
        chk("gtloss_aur", aur_rst, 1);
        tick(1);
        chk("gtloss_mmcm", mmcm_rst, 1);
        chk("gtloss_count", loss, 32'(loss1_exp));

        // Glitch on MMCM lock at STABLE count 10
        mm_in = 1'b0;
        gt_in = 1'b1;
        tick(12);
        chk("glitch_fall", mmcm_rst, 0);
        mm_in = 1'b1;
        tick(11);
        mm_in = 1'b0;
        tick(1);
        mm_in = 1'b1;
        tick(7);
        chk("glitch_nominal", ready, 0);
        tick(11);
        chk("glitch_late", ready, 0);
        tick(1);
        chk("glitch_ready", ready, 1);
        chk("glitch_retry", retry, 0);

        // MMCM loss in RUN, then lock never returns
        mm_in = 1'b0;
        tick(3);
        chk("mmloss_ready", ready, 0);
        chk("mmloss_aur", aur_rst, 1);
        tick(1);
        chk("mmloss_mmcm", mmcm_rst, 1);
        chk("mmloss_count", loss, 32'(loss2_exp));
        wait_sig(0, 1'b0, n);
        chk("pulse0_len", n, 8);
        wait_sig(0, 1'b1, n);
        chk("to1_len", n, 64);
        chk("to1_retry", retry, 1);
        wait_sig(0, 1'b0, n);
        chk("pulse1_len", n, 8);
        wait_sig(0, 1'b1, n);
        chk("to2_len", n, 64);
        chk("to2_retry", retry, 2);
        wait_sig(0, 1'b0, n);
        chk("pulse2_len", n, 8);
        wait_sig(2, 1'b1, n);
        chk("to3_len", n, 64);
        chk("fault_mmcm", mmcm_rst, 1);
        chk("fault_aur", aur_rst, 1);
        chk("fault_retry", retry, 3);
        tick(5);
        chk("fault_held", fault, 1);

        // RESTART clears FAULT
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_fault", fault, 0);
        chk("restart_retry", retry, 0);
        chk("restart_state", 32'(dut.state), 32'(ST_WAIT_GT));
        chk("restart_mmcm", mmcm_rst, 1);

        // Reset and RESTART together mid-sequence
        tick(8);
        rst_n   = 1'b0;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("both_state", 32'(dut.state), 32'(ST_WAIT_GT));
        chk("both_cnt", 32'(dut.cnt), 0);
        chk("both_mmcm", mmcm_rst, 1);
        chk("both_aur", aur_rst, 1);
        chk("both_ready", ready, 0);
        chk("both_retry", retry, 0);
        chk("both_loss", loss, 0);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
